ysyx_220053_mc_controller: RTL and testbench
============================================

// Module: ysyx_220053_mc_controller
// PURPOSE
//  Multi-cycle control unit for the NPC core; successor to the single-cycle decoder.
//  Sequences fetch/decode/execute/memory/writeback over valid/ready IFU and LSU handshakes.
//  Decodes all RV32I/RV64I base opcodes. Drives registered datapath controls, and halt/trap instead of a DPI call.
// PARAMETERS
//  XLEN         64   datapath width; 64 enables OP-IMM-32/OP-32 decode (word_op=1), 32 makes them illegal
//  TIMEOUT      255  max cycles waiting in IWAIT/MWAIT before bus-timeout trap
//  ILLEGAL_TRAP 1    1: undecodable instr -> HALT code 10; 0: executed as NOP (pc_wen only)
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous active-high reset
//  ifu_req_valid  out  1   fetch request
//  ifu_req_ready  in   1   IFU accepts request
//  ifu_rsp_valid  in   1   instruction returned
//  ifu_rsp_data   in   32  instruction word
//  lsu_req_valid  out  1   load/store request
//  lsu_req_ready  in   1   LSU accepts request
//  lsu_req_wr     out  1   1=store, 0=load
//  lsu_rsp_valid  in   1   load data / store ack returned
//  instr_q        out  32  latched instruction
//  alu_src_a      out  1   0:pc 1:rs1
//  alu_src_b      out  2   0:rs2 1:imm 2:const 4
//  ext_op         out  3   imm type I=0 U=1 S=2 B=3 J=4 R=5
//  alu_op         out  4   add 0000, sll 0001, slt 0010, sltu 0011, xor 0100, srl 0101, or 0110, and 0111, sub 1000, sra 1101, copy-B 1111
//  word_op        out  1   32-bit op, sign-extend result (XLEN=64 only)
//  branch         out  3   000 none, 001 jal, 010 jalr, 011 conditional (cond = instr_q[14:12])
//  rf_wen         out  1   register write pulse
//  pc_wen         out  1   PC update pulse
//  halt           out  1   sticky stop
//  trap_code      out  2   00 none, 01 ebreak, 10 illegal/ecall, 11 bus timeout
// BEHAVIOUR
//  Reset: state=FETCH. All outputs 0, counter 0. ifu_req_valid first rises the cycle after rst drops.
//  States: FETCH, IWAIT, DECODE, EXEC, MEM, MWAIT, WB, HALT.
//  FETCH: ifu_req_valid=1 held until ifu_req_ready=1; that cycle -> IWAIT.
//  IWAIT: capture ifu_rsp_data into instr_q when ifu_rsp_valid -> DECODE. rsp same cycle as accept is not sampled.
//  DECODE: controls registered, held stable until next DECODE.
//    Illegal -> HALT (ILLEGAL_TRAP=1). ebreak (0x00100073) -> HALT code 01. ecall -> HALT code 10.
//  EXEC: load/store -> MEM; others -> WB.
//  MEM: lsu_req_valid=1 held until lsu_req_ready -> MWAIT.
//  MWAIT: lsu_rsp_valid -> WB.
//  WB: rf_wen=1 for lui/auipc/jal/jalr/load/op-imm/op with rd!=0, else 0. pc_wen=1 always; both single-cycle. -> FETCH.
//  Latency with zero-wait memory: ALU instr 5 cycles, load/store 7 cycles, FETCH to FETCH.
//  Timeout: counter resets on entry to IWAIT/MWAIT, saturates at 8 bits. Reaching TIMEOUT without rsp -> HALT code 11.
//  HALT: halt=1, trap_code held, all req/wen outputs 0; exits only on rst.
//  rst in any state, incl. mid-handshake: next cycle state=FETCH with outputs at reset values. In-flight responses are ignored.
//  Halting instr never asserts rf_wen or pc_wen.
// TESTING
//  T1: rst, ifu ready=1, rsp 1 cycle later with 0x00500093 -> alu_op=0000, ext_op=0, src_a=1, src_b=1; rf_wen and pc_wen in cycle 5 only.
//  T2: lw 0x0000A103, lsu_rsp 3 cycles late -> lsu_req_valid, lsu_req_wr=0; one rf_wen in WB; total 10 cycles.
//  T3: sw 0x0020A023 -> lsu_req_wr=1, ext_op=2, rf_wen=0, pc_wen=1.
//  T4: ifu_req_ready low 4 cycles -> ifu_req_valid stays 1, no advance. Then addi rd=x0 (0x00000013) -> rf_wen=0.
//  T5: 0x00100073 -> halt=1, trap 01, no further ifu_req_valid. 0xFFFFFFFF after rst -> trap 10.
//  T6: withhold ifu_rsp_valid TIMEOUT cycles -> trap 11. rst during MWAIT -> lsu_req_valid=0, FETCH next cycle.

Source files
------------

// File: rtl/ysyx_220053_mc_controller_if.sv
// Fetch and load/store valid/ready handshakes between the NPC controller
// (master) and its instruction/data memory agents (slave).
interface ysyx_220053_mc_controller_if;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rsp_data;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_req_wr;
    logic        lsu_rsp_valid;

    modport master (
        output ifu_req_valid, lsu_req_valid, lsu_req_wr,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, lsu_req_ready, lsu_rsp_valid
    );
    modport slave (
        input  ifu_req_valid, lsu_req_valid, lsu_req_wr,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, lsu_req_ready, lsu_rsp_valid
    );
endinterface

// File: rtl/ysyx_220053_mc_controller.sv
// Multi-cycle NPC control unit: sequences fetch/decode/execute/mem/writeback
// over valid/ready buses, decodes RV32I/RV64I and stops with a trap code.
module ysyx_220053_mc_controller #(
    parameter int XLEN         = 64,
    parameter int TIMEOUT      = 255,
    parameter int ILLEGAL_TRAP = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    ysyx_220053_mc_controller_if.master        bus,
    output logic [31:0]                        instr_q,
    output logic                               alu_src_a,
    output logic [1:0]                         alu_src_b,
    output logic [2:0]                         ext_op,
    output logic [3:0]                         alu_op,
    output logic                               word_op,
    output logic [2:0]                         branch,
    output logic                               rf_wen,
    output logic                               pc_wen,
    output logic                               halt,
    output logic [1:0]                         trap_code
);
    typedef enum logic [2:0] {FETCH, IWAIT, DECODE, EXEC, MEM, MWAIT, WB, HALT} state_t;
    typedef struct packed {
        logic       src_a;
        logic [1:0] src_b;
        logic [2:0] ext;
        logic [3:0] alu;
        logic       word;
        logic [2:0] br;
    } ctrl_t;

    localparam logic [7:0] TO   = 8'(TIMEOUT);
    localparam bit         RV64 = (XLEN == 64);

    state_t     state;
    logic [7:0] cnt;
    logic       wb_rd, is_mem, is_st;

    ctrl_t      dc;
    logic       legal, d_wr, d_mem, d_st, d_ebrk, d_ecall;
    logic [6:0] opc, f7, shf7;
    logic [2:0] f3;

    assign opc  = instr_q[6:0];
    assign f3   = instr_q[14:12];
    assign f7   = instr_q[31:25];
    // RV64 shifts carry a 6-bit shamt, so bit 25 belongs to the immediate.
    assign shf7 = RV64 ? {instr_q[31:26], 1'b0} : f7;

    always_comb begin
        dc      = '0;
        legal   = 1'b0;
        d_wr    = 1'b0;
        d_mem   = 1'b0;
        d_st    = 1'b0;
        d_ebrk  = (instr_q == 32'h0010_0073);
        d_ecall = (instr_q == 32'h0000_0073);
        case (opc)
            7'b0110111: begin legal = 1'b1; d_wr = 1'b1; dc.ext = 3'd1; dc.src_b = 2'd1; dc.alu = 4'b1111; end
            7'b0010111: begin legal = 1'b1; d_wr = 1'b1; dc.ext = 3'd1; dc.src_b = 2'd1; end
            7'b1101111: begin legal = 1'b1; d_wr = 1'b1; dc.ext = 3'd4; dc.src_b = 2'd2; dc.br = 3'd1; end
            7'b1100111: begin legal = (f3 == 3'd0); d_wr = 1'b1; dc.src_b = 2'd2; dc.br = 3'd2; end
            7'b1100011: begin
                legal    = (f3[2:1] != 2'b01);
                dc.ext   = 3'd3;
                dc.src_a = 1'b1;
                dc.br    = 3'd3;
                dc.alu   = f3[2] ? {3'b001, f3[1]} : 4'b1000;
            end
            7'b0000011: begin
                legal    = (f3 != 3'd7) && (RV64 || (f3 != 3'd3 && f3 != 3'd6));
                d_wr     = 1'b1;
                d_mem    = 1'b1;
                dc.src_a = 1'b1;
                dc.src_b = 2'd1;
            end
            7'b0100011: begin
                legal    = !f3[2] && (RV64 || f3 != 3'd3);
                d_mem    = 1'b1;
                d_st     = 1'b1;
                dc.ext   = 3'd2;
                dc.src_a = 1'b1;
                dc.src_b = 2'd1;
            end
            7'b0010011: begin
                d_wr     = 1'b1;
                dc.src_a = 1'b1;
                dc.src_b = 2'd1;
                dc.alu   = {1'b0, f3};
                if (f3 == 3'd1) legal = (shf7 == 7'd0);
                else if (f3 == 3'd5) begin
                    legal  = (shf7 == 7'd0) || (shf7 == 7'b0100000);
                    dc.alu = {instr_q[30], f3};
                end else legal = 1'b1;
            end
            7'b0110011: begin
                legal    = (f7 == 7'd0) || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5));
                d_wr     = 1'b1;
                dc.ext   = 3'd5;
                dc.src_a = 1'b1;
                dc.alu   = {f7[5], f3};
            end
            7'b0011011: begin
                legal    = RV64 && (f3 == 3'd0 || (f3 == 3'd1 && f7 == 7'd0) ||
                                    (f3 == 3'd5 && (f7 == 7'd0 || f7 == 7'b0100000)));
                d_wr     = 1'b1;
                dc.src_a = 1'b1;
                dc.src_b = 2'd1;
                dc.word  = 1'b1;
                dc.alu   = (f3 == 3'd0) ? 4'b0000 : {instr_q[30], f3};
            end
            7'b0111011: begin
                legal    = RV64 && (((f3 == 3'd0 || f3 == 3'd5) && (f7 == 7'd0 || f7 == 7'b0100000)) ||
                                    (f3 == 3'd1 && f7 == 7'd0));
                d_wr     = 1'b1;
                dc.ext   = 3'd5;
                dc.src_a = 1'b1;
                dc.word  = 1'b1;
                dc.alu   = {f7[5], f3};
            end
            7'b0001111: legal = (f3 == 3'd0);
            7'b1110011: legal = d_ebrk || d_ecall;
            default: ;
        endcase
        // Undecodable words degrade to a NOP that only advances the PC.
        if (!legal) begin
            dc    = '0;
            d_wr  = 1'b0;
            d_mem = 1'b0;
            d_st  = 1'b0;
        end
        if (instr_q[11:7] == 5'd0) d_wr = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= FETCH;
            cnt               <= 8'd0;
            wb_rd             <= 1'b0;
            is_mem            <= 1'b0;
            is_st             <= 1'b0;
            bus.ifu_req_valid <= 1'b0;
            bus.lsu_req_valid <= 1'b0;
            bus.lsu_req_wr    <= 1'b0;
            instr_q           <= 32'd0;
            alu_src_a         <= 1'b0;
            alu_src_b         <= 2'd0;
            ext_op            <= 3'd0;
            alu_op            <= 4'd0;
            word_op           <= 1'b0;
            branch            <= 3'd0;
            rf_wen            <= 1'b0;
            pc_wen            <= 1'b0;
            halt              <= 1'b0;
            trap_code         <= 2'd0;
        end else begin
            case (state)
                FETCH: begin
                    // The request is raised on WB exit; only the first fetch after reset lands here low.
                    if (!bus.ifu_req_valid) bus.ifu_req_valid <= 1'b1;
                    else if (bus.ifu_req_ready) begin
                        bus.ifu_req_valid <= 1'b0;
                        cnt               <= 8'd0;
                        state             <= IWAIT;
                    end
                end
                IWAIT: begin
                    if (bus.ifu_rsp_valid) begin
                        instr_q <= bus.ifu_rsp_data;
                        state   <= DECODE;
                    end else if (cnt >= TO) begin
                        halt      <= 1'b1;
                        trap_code <= 2'd3;
                        state     <= HALT;
                    end else if (cnt != 8'hFF) cnt <= cnt + 8'd1;
                end
                DECODE: begin
                    alu_src_a <= dc.src_a;
                    alu_src_b <= dc.src_b;
                    ext_op    <= dc.ext;
                    alu_op    <= dc.alu;
                    word_op   <= dc.word;
                    branch    <= dc.br;
                    wb_rd     <= d_wr;
                    is_mem    <= d_mem;
                    is_st     <= d_st;
                    if (d_ebrk) begin
                        halt <= 1'b1; trap_code <= 2'd1; state <= HALT;
                    end else if (d_ecall || (!legal && ILLEGAL_TRAP != 0)) begin
                        halt <= 1'b1; trap_code <= 2'd2; state <= HALT;
                    end else state <= EXEC;
                end
                EXEC: begin
                    if (is_mem) begin
                        bus.lsu_req_valid <= 1'b1;
                        bus.lsu_req_wr    <= is_st;
                        state             <= MEM;
                    end else begin
                        rf_wen <= wb_rd;
                        pc_wen <= 1'b1;
                        state  <= WB;
                    end
                end
                MEM: begin
                    if (bus.lsu_req_ready) begin
                        bus.lsu_req_valid <= 1'b0;
                        cnt               <= 8'd0;
                        state             <= MWAIT;
                    end
                end
                MWAIT: begin
                    if (bus.lsu_rsp_valid) begin
                        rf_wen <= wb_rd;
                        pc_wen <= 1'b1;
                        state  <= WB;
                    end else if (cnt >= TO) begin
                        halt      <= 1'b1;
                        trap_code <= 2'd3;
                        state     <= HALT;
                    end else if (cnt != 8'hFF) cnt <= cnt + 8'd1;
                end
                WB: begin
                    rf_wen            <= 1'b0;
                    pc_wen            <= 1'b0;
                    bus.ifu_req_valid <= 1'b1;
                    state             <= FETCH;
                end
                default: state <= HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_220053_mc_controller.sv
// Random instruction stream from a mnemonic catalogue with random bus delays,
// checked against per-mnemonic expected controls and latency arithmetic.
module tb_ysyx_220053_mc_controller;
    localparam int TO = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_220053_mc_controller_if bus();
    logic [31:0] instr_q;
    logic        alu_src_a, word_op, rf_wen, pc_wen, halt;
    logic [1:0]  alu_src_b, trap_code;
    logic [2:0]  ext_op, branch;
    logic [3:0]  alu_op;

    ysyx_220053_mc_controller #(.XLEN(64), .TIMEOUT(TO), .ILLEGAL_TRAP(1)) dut (
        .clk(clk), .rst(rst), .bus(bus), .instr_q(instr_q), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .ext_op(ext_op), .alu_op(alu_op), .word_op(word_op),
        .branch(branch), .rf_wen(rf_wen), .pc_wen(pc_wen), .halt(halt), .trap_code(trap_code)
    );

    typedef struct packed {
        logic [6:0] opc; logic [2:0] f3; logic [6:0] f7; logic fix3, fix7;
        logic [2:0] ext; logic [3:0] alu; logic sa; logic [1:0] sb; logic [2:0] br;
        logic wo, wr, mem, st;
    } op_t;

    op_t         cat[$];
    logic [31:0] bad[6] = '{32'hFFFF_FFFF, 32'h0220_8033, 32'h0020_A063,
                            32'h3000_2573, 32'h0000_7003, 32'h4000_1013};
    int n_cmp = 0, n_bad = 0, cyc = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk); #1; cyc++;
    endtask

    function automatic op_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                               input logic fix3, input logic fix7, input logic [2:0] ext,
                               input logic [3:0] alu, input logic sa, input logic [1:0] sb,
                               input logic [2:0] br, input logic wo, input logic wr,
                               input logic mem, input logic st);
        return '{opc, f3, f7, fix3, fix7, ext, alu, sa, sb, br, wo, wr, mem, st};
    endfunction

    function automatic logic [31:0] enc(input op_t o);
        logic [31:0] w = $urandom;
        w[6:0]  = o.opc;
        w[11:7] = ($urandom_range(0, 3) == 0) ? 5'd0 : w[11:7];
        if (o.fix3) w[14:12] = o.f3;
        if (o.fix7) begin
            w[31:25] = o.f7;
            if (o.opc == 7'h13) w[25] = w[20];  // RV64 shamt[5] is free
        end
        return w;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.ifu_req_ready = 0; bus.ifu_rsp_valid = 0; bus.ifu_rsp_data = 0;
        bus.lsu_req_ready = 0; bus.lsu_rsp_valid = 0;
        step(); step();
        chk("rst_ifu_req", bus.ifu_req_valid, 0);
        chk("rst_lsu_req", bus.lsu_req_valid, 0);
        chk("rst_wen", {rf_wen, pc_wen}, 0);
        chk("rst_halt", {halt, trap_code}, 0);
        chk("rst_ctrl", {instr_q, alu_op, ext_op, branch, alu_src_b, alu_src_a, word_op}, 0);
        rst = 1'b0;
        step();
        chk("first_req", bus.ifu_req_valid, 1);
    endtask

    // Entered with the DUT showing a fetch request; returns at the next one (or at halt).
    task automatic run_instr(input logic [31:0] ins, input op_t e, input int ird, input int ird2,
                             input int lrd, input int lrsp, input logic [1:0] etrap);
        int rf = 0, pc = 0, rfc = 0, pcc = 0, lw = 0, rw = 0, exp_tot;
        logic done = 0, acc = 0, rdone = 0, lsu_seen = 0, lwr = 0, quiet = 1, ewr;
        logic [15:0] cap = '0;
        ewr = e.wr && (ins[11:7] != 5'd0);
        cyc = 1;
        for (int i = 0; i < ird; i++) begin
            step();
            chk("ifu_hold", bus.ifu_req_valid, 1);
        end
        // A response in the accept cycle must not be sampled.
        bus.ifu_req_ready = 1; bus.ifu_rsp_valid = 1; bus.ifu_rsp_data = 32'hFFFF_FFFF;
        step();
        bus.ifu_req_ready = 0; bus.ifu_rsp_valid = 0;
        for (int i = 0; i < ird2; i++) step();
        bus.ifu_rsp_valid = 1; bus.ifu_rsp_data = ins;
        step();
        bus.ifu_rsp_valid = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            if (rf_wen) begin rf++; rfc = cyc; end
            if (pc_wen) begin
                pc++; pcc = cyc;
                cap = {alu_src_a, alu_src_b, ext_op, alu_op, word_op, branch};
            end
            if (halt || bus.ifu_req_valid) done = 1;
            else begin
                bus.lsu_req_ready = 0; bus.lsu_rsp_valid = 0;
                if (bus.lsu_req_valid) begin
                    lsu_seen = 1; lwr = bus.lsu_req_wr;
                    if (lw == lrd) begin bus.lsu_req_ready = 1; acc = 1; end else lw++;
                end else if (acc && !rdone) begin
                    if (rw == lrsp) begin bus.lsu_rsp_valid = 1; rdone = 1; end else rw++;
                end
                step();
            end
        end
        bus.lsu_req_ready = 0; bus.lsu_rsp_valid = 0;
        chk("bounded_wait", done, 1);
        if (etrap != 2'd0) begin
            chk("halt", halt, 1);
            chk("trap_code", trap_code, etrap);
            chk("halt_no_wen", rf + pc, 0);
            chk("halt_no_lsu", lsu_seen, 0);
            for (int i = 0; i < 6; i++) begin
                step();
                if (bus.ifu_req_valid || bus.lsu_req_valid || rf_wen || pc_wen || !halt) quiet = 0;
            end
            chk("halt_quiet", quiet, 1);
        end else begin
            exp_tot = 5 + ird + ird2 + (e.mem ? 2 + lrd + lrsp : 0);
            chk("latency", cyc - 1, exp_tot);
            chk("no_halt", {halt, trap_code}, 0);
            chk("instr_q", instr_q, ins);
            chk("pc_wen_cnt", pc, 1);
            chk("pc_wen_cyc", pcc, exp_tot);
            chk("rf_wen_cnt", rf, ewr);
            if (ewr) chk("rf_wen_cyc", rfc, exp_tot);
            chk("lsu_used", lsu_seen, e.mem);
            if (e.mem) chk("lsu_wr", lwr, e.st);
            chk("ctrl", cap, {e.sa, e.sb, e.ext, e.alu, e.wo, e.br});
        end
    endtask

    task automatic issue(input logic [31:0] ins);
        bus.ifu_req_ready = 1; step(); bus.ifu_req_ready = 0;
        bus.ifu_rsp_valid = 1; bus.ifu_rsp_data = ins; step(); bus.ifu_rsp_valid = 0;
    endtask

    initial begin
        op_t o;
        // opc f3 f7 fix3 fix7 | ext alu sa sb br wo wr mem st
        cat.push_back(mk(7'h37, 0, 0, 0, 0, 1, 4'hF, 0, 1, 0, 0, 1, 0, 0));  // lui
        cat.push_back(mk(7'h17, 0, 0, 0, 0, 1, 4'h0, 0, 1, 0, 0, 1, 0, 0));  // auipc
        cat.push_back(mk(7'h6F, 0, 0, 0, 0, 4, 4'h0, 0, 2, 1, 0, 1, 0, 0));  // jal
        cat.push_back(mk(7'h67, 0, 0, 1, 0, 0, 4'h0, 0, 2, 2, 0, 1, 0, 0));  // jalr
        cat.push_back(mk(7'h63, 0, 0, 1, 0, 3, 4'h8, 1, 0, 3, 0, 0, 0, 0));  // beq
        cat.push_back(mk(7'h63, 1, 0, 1, 0, 3, 4'h8, 1, 0, 3, 0, 0, 0, 0));  // bne
        cat.push_back(mk(7'h63, 4, 0, 1, 0, 3, 4'h2, 1, 0, 3, 0, 0, 0, 0));  // blt
        cat.push_back(mk(7'h63, 5, 0, 1, 0, 3, 4'h2, 1, 0, 3, 0, 0, 0, 0));  // bge
        cat.push_back(mk(7'h63, 6, 0, 1, 0, 3, 4'h3, 1, 0, 3, 0, 0, 0, 0));  // bltu
        cat.push_back(mk(7'h63, 7, 0, 1, 0, 3, 4'h3, 1, 0, 3, 0, 0, 0, 0));  // bgeu
        for (int f = 0; f < 7; f++)                                          // lb..lwu, ld
            cat.push_back(mk(7'h03, 3'(f), 0, 1, 0, 0, 4'h0, 1, 1, 0, 0, 1, 1, 0));
        for (int f = 0; f < 4; f++)                                          // sb..sd
            cat.push_back(mk(7'h23, 3'(f), 0, 1, 0, 2, 4'h0, 1, 1, 0, 0, 0, 1, 1));
        cat.push_back(mk(7'h13, 0, 0, 1, 0, 0, 4'h0, 1, 1, 0, 0, 1, 0, 0));  // addi
        cat.push_back(mk(7'h13, 2, 0, 1, 0, 0, 4'h2, 1, 1, 0, 0, 1, 0, 0));  // slti
        cat.push_back(mk(7'h13, 3, 0, 1, 0, 0, 4'h3, 1, 1, 0, 0, 1, 0, 0));  // sltiu
        cat.push_back(mk(7'h13, 4, 0, 1, 0, 0, 4'h4, 1, 1, 0, 0, 1, 0, 0));  // xori
        cat.push_back(mk(7'h13, 6, 0, 1, 0, 0, 4'h6, 1, 1, 0, 0, 1, 0, 0));  // ori
        cat.push_back(mk(7'h13, 7, 0, 1, 0, 0, 4'h7, 1, 1, 0, 0, 1, 0, 0));  // andi
        cat.push_back(mk(7'h13, 1, 7'h00, 1, 1, 0, 4'h1, 1, 1, 0, 0, 1, 0, 0));  // slli
        cat.push_back(mk(7'h13, 5, 7'h00, 1, 1, 0, 4'h5, 1, 1, 0, 0, 1, 0, 0));  // srli
        cat.push_back(mk(7'h13, 5, 7'h20, 1, 1, 0, 4'hD, 1, 1, 0, 0, 1, 0, 0));  // srai
        cat.push_back(mk(7'h33, 0, 7'h00, 1, 1, 5, 4'h0, 1, 0, 0, 0, 1, 0, 0));  // add
        cat.push_back(mk(7'h33, 0, 7'h20, 1, 1, 5, 4'h8, 1, 0, 0, 0, 1, 0, 0));  // sub
        cat.push_back(mk(7'h33, 1, 7'h00, 1, 1, 5, 4'h1, 1, 0, 0, 0, 1, 0, 0));  // sll
        cat.push_back(mk(7'h33, 3, 7'h00, 1, 1, 5, 4'h3, 1, 0, 0, 0, 1, 0, 0));  // sltu
        cat.push_back(mk(7'h33, 5, 7'h20, 1, 1, 5, 4'hD, 1, 0, 0, 0, 1, 0, 0));  // sra
        cat.push_back(mk(7'h33, 7, 7'h00, 1, 1, 5, 4'h7, 1, 0, 0, 0, 1, 0, 0));  // and
        cat.push_back(mk(7'h1B, 0, 0, 1, 0, 0, 4'h0, 1, 1, 0, 1, 1, 0, 0));      // addiw
        cat.push_back(mk(7'h1B, 1, 7'h00, 1, 1, 0, 4'h1, 1, 1, 0, 1, 1, 0, 0));  // slliw
        cat.push_back(mk(7'h1B, 5, 7'h20, 1, 1, 0, 4'hD, 1, 1, 0, 1, 1, 0, 0));  // sraiw
        cat.push_back(mk(7'h3B, 0, 7'h20, 1, 1, 5, 4'h8, 1, 0, 0, 1, 1, 0, 0));  // subw
        cat.push_back(mk(7'h3B, 5, 7'h00, 1, 1, 5, 4'h5, 1, 0, 0, 1, 1, 0, 0));  // srlw
        cat.push_back(mk(7'h0F, 0, 0, 1, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0));      // fence

        do_reset();
        // addi x1,x0,5 with zero-wait fetch
        run_instr(32'h0050_0093, mk(7'h13, 0, 0, 1, 0, 0, 4'h0, 1, 1, 0, 0, 1, 0, 0), 0, 0, 0, 0, 2'd0);
        // lw x2,0(x1) with a 3-cycle late load response
        run_instr(32'h0000_A103, mk(7'h03, 2, 0, 1, 0, 0, 4'h0, 1, 1, 0, 0, 1, 1, 0), 0, 0, 0, 3, 2'd0);
        // sw x2,0(x1)
        run_instr(32'h0020_A023, mk(7'h23, 2, 0, 1, 0, 2, 4'h0, 1, 1, 0, 0, 0, 1, 1), 0, 0, 0, 0, 2'd0);
        // addi x0,x0,0 behind a fetch held off for 4 cycles
        run_instr(32'h0000_0013, mk(7'h13, 0, 0, 1, 0, 0, 4'h0, 1, 1, 0, 0, 1, 0, 0), 4, 0, 0, 0, 2'd0);
        run_instr(32'h0010_0073, '0, 0, 0, 0, 0, 2'd1);  // ebreak
        do_reset();
        run_instr(32'hFFFF_FFFF, '0, 0, 1, 0, 0, 2'd2);  // illegal
        do_reset();
        run_instr(32'h0000_0073, '0, 1, 0, 0, 0, 2'd2);  // ecall
        do_reset();

        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                run_instr(bad[$urandom_range(0, 5)], '0, $urandom_range(0, 2), $urandom_range(0, 2), 0, 0, 2'd2);
                do_reset();
            end else begin
                o = cat[$urandom_range(0, cat.size() - 1)];
                run_instr(enc(o), o, $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 3), 2'd0);
            end
        end

        // Instruction response withheld: bus-timeout trap
        bus.ifu_req_ready = 1; step(); bus.ifu_req_ready = 0;
        repeat (TO - 5) step();
        chk("ito_early", halt, 0);
        repeat (10) step();
        chk("ito_halt", {halt, trap_code}, 3'b111);
        chk("ito_req", bus.ifu_req_valid, 0);
        do_reset();

        // Load response withheld: bus-timeout trap
        issue(32'h0000_A103); step(); step();
        chk("mem_req", bus.lsu_req_valid, 1);
        bus.lsu_req_ready = 1; step(); bus.lsu_req_ready = 0;
        repeat (TO - 5) step();
        chk("mto_early", halt, 0);
        repeat (10) step();
        chk("mto_halt", {halt, trap_code}, 3'b111);
        chk("mto_no_wen", {rf_wen, pc_wen, bus.lsu_req_valid}, 0);
        do_reset();

        // Reset while waiting on a load, with its response arriving during reset
        issue(32'h0000_A103); step(); step();
        bus.lsu_req_ready = 1; step(); bus.lsu_req_ready = 0;
        rst = 1; bus.lsu_rsp_valid = 1; step();
        chk("rstmw_lsu", bus.lsu_req_valid, 0);
        chk("rstmw_wen", {rf_wen, pc_wen, bus.ifu_req_valid}, 0);
        rst = 0; bus.lsu_rsp_valid = 0; step();
        chk("rstmw_fetch", bus.ifu_req_valid, 1);
        chk("rstmw_state", {halt, trap_code, rf_wen, pc_wen}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
